roce_payload_gen: RTL and testbench
===================================

ROCE_PAYLOAD_GEN -- requirements
Module: roce_payload_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning payload bus width in bits; legal values 64, 128, 256, 512.
REQ-002 SHALL have parameter KEEP_WIDTH, default DATA_WIDTH/8, meaning tkeep width.
REQ-003 SHALL have one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-004 SHALL provide these ports:
- clk  in  1  clock
- rst  in  1  async active-high reset
- s_start  in  1  level; its rising edge starts a transfer
- s_abort  in  1  level; requests early termination
- s_length  in  32  transfer length in bytes
- s_mode  in  2  pattern: 0 incrementing, 1 counter/inverted, 2 PRBS31, 3 constant
- s_seed  in  32  constant fill value, or PRBS seed
- m_axis_tdata  out  DATA_WIDTH  payload
- m_axis_tkeep  out  KEEP_WIDTH  byte enables
- m_axis_tvalid  out  1  beat valid
- m_axis_tready  in  1  sink ready
- m_axis_tlast  out  1  last beat
- m_axis_tuser  out  1  beat belongs to an aborted frame
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse at transfer end
- bytes_sent  out  32  bytes accepted in the current or last transfer

Function
REQ-005 SHALL detect the s_start edge with an internal registered copy; a start edge seen while busy SHALL be ignored.
REQ-006 SHALL implement the FSM IDLE->RUN on a start edge, RUN->DONE on the handshake of a beat with tlast, and DONE->IDLE after one cycle.
REQ-007 SHALL, on a start edge, latch s_length, s_mode and s_seed and clear bytes_sent; the inputs are don't-care afterwards.
REQ-008 SHALL, when the latched length is 0, go IDLE->DONE, emit no beat and pulse done.
REQ-009 SHALL assert tvalid on the clock edge after the edge that detects start, and SHALL emit ceil(length/KEEP_WIDTH) beats.
REQ-010 SHALL hold tdata/tkeep/tlast/tuser stable while tvalid=1 and tready=0, and SHALL advance only on a tvalid&tready handshake; there is no bubble between beats while tready=1.
REQ-011 SHALL drive tkeep all ones except on the last beat, where it is count2keep(length mod KEEP_WIDTH), or all ones when that remainder is 0.
REQ-012 SHALL set beat offset O = 32-bit byte offset of the beat (beat index * KEEP_WIDTH), wrapping mod 2^32.
REQ-013 SHALL fill 32-bit lane i as follows:
- mode 0: O + 4i
- mode 1: even lanes O, odd lanes ~O
- mode 2: successive PRBS31 words
- mode 3: seed
REQ-014 SHALL run the PRBS31 generator (x^31+x^28+1), seeded with the latched seed (0 replaced by 1), producing DATA_WIDTH/32 words per accepted beat.
REQ-015 SHALL increase bytes_sent by popcount(tkeep) on each handshake, saturating at 2^32-1.
REQ-016 SHALL handle s_abort high in RUN as follows: if the pending beat is not last, the next beat produced after its handshake is final, with tlast=1, tuser=1 and tkeep all ones.
REQ-017 SHALL leave an already-pending beat unchanged by abort, and SHALL ignore abort when the pending beat is already last.
REQ-018 SHALL drive busy=1 in RUN and DONE only, and done=1 only in DONE.

Reset
REQ-019 SHALL on rst force state IDLE and drive tvalid, tlast, tuser, tdata, tkeep, busy, done, bytes_sent and the start-edge register to 0.
REQ-020 SHALL, on reset mid-transfer, drop the frame immediately (no tlast emitted), and SHALL require a new start edge after reset release.

Configuration
REQ-021 SHALL compile in the PRBS generator only when ROCE_PAYLOAD_GEN_PRBS_EN is defined; without it, mode 2 SHALL behave exactly as mode 0 and no LFSR logic is built.

Structure
REQ-022 SHALL place the mode encoding constants and the count2keep/keep2count functions in shared package roce_payload_gen_pkg.
REQ-023 SHALL implement the PRBS as sub-module roce_prbs31_gen (parameter WORDS; load, advance and data outputs).

Verification
REQ-024 SHALL cover: DATA_WIDTH=64, length=20, mode 1, tready=1 -> 3 beats, tdata 0xFFFFFFFF_00000000, 0xFFFFFFF7_00000008, 0xFFFFFFEF_00000010; last beat tkeep=0x0F, tlast=1; done pulse; bytes_sent=20.
REQ-025 SHALL cover: DATA_WIDTH=128, length=32, mode 0 -> 2 beats, beat1 lanes 0x10,0x14,0x18,0x1C, tkeep=0xFFFF on both beats.
REQ-026 SHALL cover: length=0 -> no tvalid, done=1 for exactly one cycle, busy high for one cycle.
REQ-027 SHALL cover: length=64, tready toggled 1-0-0-1 -> tdata/tkeep held during stalls, 8 beats total, bytes_sent=64.
REQ-028 SHALL cover: length=1024, abort raised at beat 3 -> beat 4 has tlast=1, tuser=1; then done; bytes_sent=40.
REQ-029 SHALL cover: rst asserted at beat 5 -> tvalid=0 and busy=0 at once; s_start held high after release starts nothing until it toggles low then high.

Source files
------------

// File: rtl/roce_payload_gen_pkg.sv
// Shared types, pattern mode encodings and byte-enable helpers for the RoCE payload generator.
package roce_payload_gen_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  localparam logic [1:0] MODE_INC   = 2'd0;
  localparam logic [1:0] MODE_CNT   = 2'd1;
  localparam logic [1:0] MODE_PRBS  = 2'd2;
  localparam logic [1:0] MODE_CONST = 2'd3;

  localparam int MAX_KEEP = 64;

  // n low-order ones; callers truncate to their own tkeep width.
  function automatic logic [MAX_KEEP-1:0] count2keep(input logic [6:0] n);
    logic [MAX_KEEP-1:0] k;
    k = '0;
    for (int i = 0; i < MAX_KEEP; i++) k[i] = (i < int'(n));
    return k;
  endfunction

  function automatic logic [7:0] keep2count(input logic [MAX_KEEP-1:0] k);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < MAX_KEEP; i++) c = c + 8'(k[i]);
    return c;
  endfunction

endpackage

// File: rtl/roce_prbs31_gen.sv
// PRBS31 (x^31+x^28+1) word source: WORDS 32-bit words per advance, first generated bit in each word's MSB.
module roce_prbs31_gen #(
  parameter int WORDS = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [30:0]        seed,
  input  logic               advance,
  output logic [WORDS*32-1:0] data
);

  logic [30:0] state, state_nxt;

  always_comb begin
    logic [30:0] s;
    s    = state;
    data = '0;
    for (int w = 0; w < WORDS; w++) begin
      for (int b = 31; b >= 0; b--) begin
        data[32*w+b] = s[30] ^ s[27];
        s = {s[29:0], s[30] ^ s[27]};
      end
    end
    state_nxt = s;
  end

  // An all-zero seed would lock the LFSR, so it is replaced with 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          state <= 31'd1;
    else if (load)    state <= (seed == '0) ? 31'd1 : seed;
    else if (advance) state <= state_nxt;
  end

endmodule

// File: rtl/roce_payload_gen.sv
// AXI-Stream payload generator: one frame per s_start rising edge, patterned data, abort and byte count.
// Optional PRBS31 mode is built only with ROCE_PAYLOAD_GEN_PRBS_EN defined (otherwise mode 2 = mode 0).
module roce_payload_gen
  import roce_payload_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH/8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_start,
  input  logic                  s_abort,
  input  logic [31:0]           s_length,
  input  logic [1:0]            s_mode,
  input  logic [31:0]           s_seed,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           bytes_sent
);

  localparam int WORDS = DATA_WIDTH/32;
  localparam int KB    = $clog2(KEEP_WIDTH);

  state_t          state;
  logic            start_q, armed;
  logic [1:0]      mode_q;
  logic [31:0]     seed_q;
  logic [KB-1:0]   rem_q;
  logic [31:0]     beats_left, offset;
  logic            abort_q;

  logic            start_go, hs, produce, abort_now, last_beat;
  logic [32:0]     len_up, bsum;
  logic [31:0]     beats_init;
  logic [DATA_WIDTH-1:0] beat_data;
  logic [KEEP_WIDTH-1:0] beat_keep;

  // armed stays low after reset until s_start is seen low, so a held start cannot retrigger.
  assign start_go   = s_start & ~start_q & armed & (state == ST_IDLE);
  assign hs         = m_axis_tvalid & m_axis_tready;
  assign produce    = (state == ST_RUN) && (beats_left != '0) &&
                      (!m_axis_tvalid || (m_axis_tready && !m_axis_tlast));
  assign abort_now  = abort_q | (s_abort & m_axis_tvalid & ~m_axis_tlast);
  assign last_beat  = (beats_left == 32'd1) | abort_now;
  assign len_up     = {1'b0, s_length} + 33'(KEEP_WIDTH - 1);
  assign beats_init = 32'(len_up >> KB);
  assign bsum       = {1'b0, bytes_sent} + 33'(keep2count(64'(m_axis_tkeep)));

`ifdef ROCE_PAYLOAD_GEN_PRBS_EN
  logic [DATA_WIDTH-1:0] prbs_data;

  roce_prbs31_gen #(.WORDS(WORDS)) u_prbs (
    .clk     (clk),
    .rst     (rst),
    .load    (start_go),
    .seed    (s_seed[30:0]),
    .advance (produce && (mode_q == MODE_PRBS)),
    .data    (prbs_data)
  );
`endif

  always_comb begin
    beat_data = '0;
    for (int i = 0; i < WORDS; i++) begin
      case (mode_q)
        MODE_CNT:   beat_data[32*i +: 32] = (i % 2 == 1) ? ~offset : offset;
`ifdef ROCE_PAYLOAD_GEN_PRBS_EN
        MODE_PRBS:  beat_data[32*i +: 32] = prbs_data[32*i +: 32];
`endif
        MODE_CONST: beat_data[32*i +: 32] = seed_q;
        default:    beat_data[32*i +: 32] = offset + 32'(4*i);
      endcase
    end
    // An aborted frame ends on a full beat; a natural end carries the length remainder.
    beat_keep = '1;
    if (!abort_now && beats_left == 32'd1 && rem_q != '0)
      beat_keep = KEEP_WIDTH'(count2keep(7'(rem_q)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      start_q       <= 1'b0;
      armed         <= 1'b0;
      mode_q        <= '0;
      seed_q        <= '0;
      rem_q         <= '0;
      beats_left    <= '0;
      offset        <= '0;
      abort_q       <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      bytes_sent    <= '0;
    end else begin
      start_q <= s_start;
      if (!s_start) armed <= 1'b1;
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_go) begin
            mode_q     <= s_mode;
            seed_q     <= s_seed;
            rem_q      <= s_length[KB-1:0];
            beats_left <= beats_init;
            offset     <= '0;
            abort_q    <= 1'b0;
            bytes_sent <= '0;
            busy       <= 1'b1;
            if (s_length == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (hs) bytes_sent <= bsum[32] ? 32'hFFFF_FFFF : bsum[31:0];
          if (s_abort && m_axis_tvalid && !m_axis_tlast) abort_q <= 1'b1;
          if (produce) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= beat_data;
            m_axis_tkeep  <= beat_keep;
            m_axis_tlast  <= last_beat;
            m_axis_tuser  <= abort_now;
            offset        <= offset + 32'(KEEP_WIDTH);
            beats_left    <= beats_left - 32'd1;
          end else if (hs) begin
            // Only the tlast beat can be accepted without a successor.
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            state         <= ST_DONE;
            done          <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_roce_payload_gen.sv
// Self-checking bench for roce_payload_gen: scoreboard of expected beats, one task per scenario.
module tb_roce_payload_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_start = 1'b0, s_abort = 1'b0;
  logic [31:0] s_length = '0, s_seed = '0;
  logic [1:0]  s_mode = '0;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tvalid, tready = 1'b1, tlast, tuser, busy, done;
  logic [31:0] bytes_sent;

  logic         s_start2 = 1'b0, tready2 = 1'b1;
  logic [127:0] tdata2;
  logic [15:0]  tkeep2;
  logic         tvalid2, tlast2, tuser2, busy2, done2;
  logic [31:0]  bytes2;

  int pass_cnt = 0, chk_cnt = 0;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic        u;
  } beat_t;
  beat_t sbq[$];
  logic [127:0] sbq128[$];
  logic [30:0]  prbs_s;

  always #5 clk = ~clk;

  roce_payload_gen dut (
    .clk(clk), .rst(rst), .s_start(s_start), .s_abort(s_abort), .s_length(s_length),
    .s_mode(s_mode), .s_seed(s_seed), .m_axis_tdata(tdata), .m_axis_tkeep(tkeep),
    .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tlast(tlast),
    .m_axis_tuser(tuser), .busy(busy), .done(done), .bytes_sent(bytes_sent)
  );

  roce_payload_gen #(.DATA_WIDTH(128)) dut128 (
    .clk(clk), .rst(rst), .s_start(s_start2), .s_abort(1'b0), .s_length(s_length),
    .s_mode(s_mode), .s_seed(s_seed), .m_axis_tdata(tdata2), .m_axis_tkeep(tkeep2),
    .m_axis_tvalid(tvalid2), .m_axis_tready(tready2), .m_axis_tlast(tlast2),
    .m_axis_tuser(tuser2), .busy(busy2), .done(done2), .bytes_sent(bytes2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected 64-bit beat idx of a frame.
  function automatic beat_t model(input int idx, input int len, input int md, input logic [31:0] sd,
                                  input bit last, input bit user);
    beat_t e;
    logic [31:0] o;
    int r;
    o = 32'(idx * 8);
    r = len % 8;
    case (md)
      1: e.d = {~o, o};
      3: e.d = {sd, sd};
`ifdef ROCE_PAYLOAD_GEN_PRBS_EN
      2: begin
        if (idx == 0) prbs_s = (sd[30:0] == '0) ? 31'd1 : sd[30:0];
        for (int w = 0; w < 2; w++)
          for (int b = 31; b >= 0; b--) begin
            e.d[32*w+b] = prbs_s[30] ^ prbs_s[27];
            prbs_s = {prbs_s[29:0], prbs_s[30] ^ prbs_s[27]};
          end
      end
`endif
      default: e.d = {o + 32'd4, o};
    endcase
    e.k = (last && !user && r != 0) ? 8'((9'h1 << r) - 1) : 8'hFF;
    e.l = last;
    e.u = user;
    return e;
  endfunction

  task automatic test_reset();
    #1;
    chk_cnt++;
    if ({tvalid, tlast, tuser, busy, done} !== 5'b0 || tdata !== '0 || tkeep !== '0 || bytes_sent !== '0)
      $display("FAIL reset_outputs: valid=%b last=%b user=%b busy=%b done=%b data=%h keep=%h bytes=%0d, want all 0",
               tvalid, tlast, tuser, busy, done, tdata, tkeep, bytes_sent);
    else pass_cnt++;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step();
  endtask

  task automatic run_frame(input string nm, input int len, input int md, input logic [31:0] sd,
                           input bit stall, input int abort_at);
    int n, got, exp_bytes;
    bit aborted, seen_done;
    beat_t e;
    n = (len + 7) / 8;
    aborted = 1'b0;
    if (abort_at >= 0 && abort_at < n - 1) begin
      n = abort_at + 2;
      aborted = 1'b1;
    end
    exp_bytes = aborted ? n * 8 : len;
    for (int b = 0; b < n; b++) sbq.push_back(model(b, len, md, sd, b == n - 1, aborted && b == n - 1));
    s_length = len; s_mode = 2'(md); s_seed = sd; s_start = 1'b1;
    step();
    // Inputs are don't-care once the start edge has been taken.
    s_start = 1'b0; s_length = 32'h0000_DEAD; s_mode = 2'(md + 1); s_seed = ~sd;
    chk_cnt++;
    if (busy !== 1'b1 || tvalid !== 1'b0)
      $display("FAIL %s_start_latency: busy=%b valid=%b, want busy=1 valid=0", nm, busy, tvalid);
    else pass_cnt++;
    got = 0;
    seen_done = 1'b0;
    for (int cyc = 0; cyc < 400 && !seen_done; cyc++) begin
      step();
      if (cyc == 0) begin
        chk_cnt++;
        if (tvalid !== 1'b1) $display("FAIL %s_first_valid: valid=%b, want 1", nm, tvalid);
        else pass_cnt++;
      end
      if (done === 1'b1) begin
        seen_done = 1'b1;
        chk_cnt++;
        if (bytes_sent !== 32'(exp_bytes) || got != n || sbq.size() != 0 || busy !== 1'b1)
          $display("FAIL %s_done: bytes=%0d beats=%0d busy=%b, want bytes=%0d beats=%0d busy=1",
                   nm, bytes_sent, got, busy, exp_bytes, n);
        else pass_cnt++;
      end
      tready = stall ? !((cyc % 4) == 1 || (cyc % 4) == 2) : 1'b1;
      s_abort = (abort_at >= 0 && got == abort_at && tvalid === 1'b1);
      if (tvalid === 1'b1) begin
        chk_cnt++;
        if (sbq.size() == 0) begin
          $display("FAIL %s_extra_beat: got data=%h, want no beat", nm, tdata);
        end else begin
          e = sbq[0];
          if (tdata !== e.d || tkeep !== e.k || tlast !== e.l || tuser !== e.u)
            $display("FAIL %s_beat%0d: data=%h keep=%h last=%b user=%b, want data=%h keep=%h last=%b user=%b",
                     nm, got, tdata, tkeep, tlast, tuser, e.d, e.k, e.l, e.u);
          else pass_cnt++;
        end
        if (tready && sbq.size() != 0) begin
          void'(sbq.pop_front());
          got++;
        end
      end
    end
    s_abort = 1'b0;
    tready = 1'b1;
    if (!seen_done) begin
      chk_cnt++;
      $display("FAIL %s_timeout: no done pulse, beats=%0d want %0d", nm, got, n);
      sbq.delete();
    end
    step();
    chk_cnt++;
    if (done !== 1'b0 || busy !== 1'b0 || tvalid !== 1'b0)
      $display("FAIL %s_after_done: done=%b busy=%b valid=%b, want 0 0 0", nm, done, busy, tvalid);
    else pass_cnt++;
  endtask

  task automatic test_len_zero();
    s_length = 0; s_mode = 0; s_start = 1'b1;
    step();
    s_start = 1'b0;
    chk_cnt++;
    if (done !== 1'b1 || busy !== 1'b1 || tvalid !== 1'b0)
      $display("FAIL len0_done: done=%b busy=%b valid=%b, want 1 1 0", done, busy, tvalid);
    else pass_cnt++;
    step();
    chk_cnt++;
    if (done !== 1'b0 || busy !== 1'b0 || tvalid !== 1'b0)
      $display("FAIL len0_after: done=%b busy=%b valid=%b, want 0 0 0", done, busy, tvalid);
    else pass_cnt++;
  endtask

  task automatic test_wide_128();
    int got;
    bit seen_done;
    sbq128.push_back(128'h0000000C_00000008_00000004_00000000);
    sbq128.push_back(128'h0000001C_00000018_00000014_00000010);
    s_length = 32; s_mode = 0; s_start2 = 1'b1;
    step();
    s_start2 = 1'b0;
    got = 0;
    seen_done = 1'b0;
    for (int cyc = 0; cyc < 20 && !seen_done; cyc++) begin
      step();
      if (done2 === 1'b1) begin
        seen_done = 1'b1;
        chk_cnt++;
        if (got != 2 || bytes2 !== 32'd32)
          $display("FAIL w128_done: beats=%0d bytes=%0d, want 2 32", got, bytes2);
        else pass_cnt++;
      end
      if (tvalid2 === 1'b1) begin
        chk_cnt++;
        if (sbq128.size() == 0) begin
          $display("FAIL w128_extra_beat: data=%h", tdata2);
        end else begin
          if (tdata2 !== sbq128[0] || tkeep2 !== 16'hFFFF || tlast2 !== (got == 1) || tuser2 !== 1'b0)
            $display("FAIL w128_beat%0d: data=%h keep=%h last=%b, want data=%h keep=ffff last=%b",
                     got, tdata2, tkeep2, tlast2, sbq128[0], got == 1);
          else pass_cnt++;
          void'(sbq128.pop_front());
          got++;
        end
      end
    end
    if (!seen_done) begin
      chk_cnt++;
      $display("FAIL w128_timeout: no done pulse, beats=%0d want 2", got);
      sbq128.delete();
    end
    step();
  endtask

  task automatic test_reset_mid();
    int got;
    beat_t e;
    s_length = 1024; s_mode = 0; s_seed = 0; s_start = 1'b1;
    tready = 1'b1;
    step();
    got = 0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      step();
      if (tvalid === 1'b1) begin
        if (got == 5) break;
        got++;
      end
    end
    chk_cnt++;
    if (got != 5) $display("FAIL rstmid_reach_beat5: beats=%0d, want 5", got);
    else pass_cnt++;
    rst = 1'b1;
    #1;
    chk_cnt++;
    if (tvalid !== 1'b0 || busy !== 1'b0 || tlast !== 1'b0)
      $display("FAIL rstmid_drop: valid=%b busy=%b last=%b, want 0 0 0", tvalid, busy, tlast);
    else pass_cnt++;
    repeat (2) step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_cnt++;
      if (busy !== 1'b0 || tvalid !== 1'b0)
        $display("FAIL rstmid_held_start%0d: busy=%b valid=%b, want 0 0", i, busy, tvalid);
      else pass_cnt++;
    end
    s_start = 1'b0;
    step();
    s_start = 1'b1;
    step();
    chk_cnt++;
    if (busy !== 1'b1) $display("FAIL rstmid_restart_busy: busy=%b, want 1", busy);
    else pass_cnt++;
    step();
    e = model(0, 1024, 0, 32'h0, 1'b0, 1'b0);
    chk_cnt++;
    if (tvalid !== 1'b1 || tdata !== e.d || tkeep !== e.k || tlast !== 1'b0)
      $display("FAIL rstmid_restart_beat0: valid=%b data=%h keep=%h last=%b, want 1 %h %h 0",
               tvalid, tdata, tkeep, tlast, e.d, e.k);
    else pass_cnt++;
    s_start = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    run_frame("mode1_len20", 20, 1, 32'h0, 1'b0, -1);
    test_wide_128();
    test_len_zero();
    run_frame("stall_len64", 64, 0, 32'h0, 1'b1, -1);
    run_frame("abort_len1024", 1024, 0, 32'h0, 1'b0, 3);
    run_frame("const_len17", 17, 3, 32'hA5C3_0F1E, 1'b0, -1);
    run_frame("inc_len8", 8, 0, 32'h0, 1'b0, -1);
    run_frame("mode2_len24", 24, 2, 32'h1234_5678, 1'b1, -1);
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
